// File: rtl/llc_rst_flush_seq_pkg.sv
// Shared types and default sizing for the LLC reset/flush sequencer.
// Optional feature macro used by the sequencer: LLC_FLUSH_WB_CNT_EN.
package llc_rst_flush_seq_pkg;

    localparam int LLC_WAYS_DEF     = 16;
    localparam int LLC_SETS_DEF     = 256;
    localparam int LLC_TAG_BITS_DEF = 20;

    // Saturation value of the optional flush writeback counter.
    localparam logic [15:0] WB_CNT_MAX = 16'hFFFF;

    // Walk sequencer states.
    typedef enum logic [2:0] {
        IDLE,
        RST_CLR,
        FL_RD,
        FL_SCAN,
        FL_WB,
        FL_INV
    } llc_rf_state_t;

endpackage

// File: rtl/llc_way_prio_enc.sv
// Lowest-index priority encoder over a per-way mask.
// Purely combinational; also used by the eviction logic.
module llc_way_prio_enc
    import llc_rst_flush_seq_pkg::*;
#(
    parameter int WAYS = LLC_WAYS_DEF,
    localparam int WAY_BITS = $clog2(WAYS)
) (
    input  logic [WAYS-1:0]     mask,
    output logic [WAY_BITS-1:0] way,
    output logic                any
);

    // below[i] is set when any mask bit with index < i is set.
    logic [WAYS:0]   below;
    logic [WAYS-1:0] first;

    assign below[0] = 1'b0;

    generate
        for (genvar gi = 0; gi < WAYS; gi++) begin : g_chain
            assign below[gi+1] = below[gi] | mask[gi];
            assign first[gi]   = mask[gi] & ~below[gi];
        end
    endgenerate

    assign any = below[WAYS];

    // Convert the one-hot lowest bit into a binary way index.
    always_comb begin
        way = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (first[i]) begin
                way = way | WAY_BITS'(i);
            end
        end
    end

endmodule

// File: rtl/llc_rst_flush_seq.sv
// LLC reset-clear / flush walk sequencer.
// Reset walk invalidates every set; flush walk writes back every valid dirty
// way of a set and then invalidates it. The current set lives in the register
// file; this block only issues incr/clr pulses for it.
// Optional: define LLC_FLUSH_WB_CNT_EN to add the flush_wb_cnt output.
module llc_rst_flush_seq
    import llc_rst_flush_seq_pkg::*;
#(
    parameter int LLC_WAYS = LLC_WAYS_DEF,
    parameter int LLC_SETS = LLC_SETS_DEF,
    parameter int TAG_BITS = LLC_TAG_BITS_DEF,
    localparam int SET_BITS  = $clog2(LLC_SETS),
    localparam int WAY_BITS  = $clog2(LLC_WAYS),
    localparam int LINE_BITS = TAG_BITS + SET_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rst_state,
    input  logic                 rst_stall,
    input  logic                 flush_stall,
    input  logic [SET_BITS-1:0]  rst_flush_stalled_set,
    input  logic [TAG_BITS-1:0]  tags_buf [LLC_WAYS],
    input  logic [LLC_WAYS-1:0]  valid_buf,
    input  logic [LLC_WAYS-1:0]  dirty_buf,
    output logic                 rd_set_en,
    output logic                 wr_inv_set_en,
    output logic                 wb_valid,
    input  logic                 wb_ready,
    output logic [LINE_BITS-1:0] wb_line_addr,
    output logic [WAY_BITS-1:0]  wb_way,
    output logic                 incr_rst_flush_stalled_set,
    output logic                 clr_rst_flush_stalled_set,
    output logic                 clr_rst_stall,
    output logic                 clr_flush_stall,
    output logic                 busy
`ifdef LLC_FLUSH_WB_CNT_EN
    ,
    output logic [15:0]          flush_wb_cnt
`endif
);

    localparam logic [SET_BITS-1:0] LAST_SET = SET_BITS'(LLC_SETS - 1);

    llc_rf_state_t       state_reg;
    logic [LLC_WAYS-1:0] pend_reg;
    logic [TAG_BITS-1:0] tag_reg [LLC_WAYS];

    logic                handshake;
    logic [SET_BITS-1:0] pred_set;
    logic                pred_last;
    logic [LLC_WAYS-1:0] done_mask;
    logic [LLC_WAYS-1:0] enc_in;
    logic [WAY_BITS-1:0] enc_way;
    logic                enc_any;
    logic [TAG_BITS-1:0] enc_tag;

    // Outputs are registered, so the set the regs will hold next cycle is
    // predicted from the pulses being presented this cycle.
    always_comb begin
        handshake = wb_valid & wb_ready;
        if (clr_rst_flush_stalled_set) begin
            pred_set = '0;
        end else if (incr_rst_flush_stalled_set) begin
            pred_set = rst_flush_stalled_set + SET_BITS'(1);
        end else begin
            pred_set = rst_flush_stalled_set;
        end
        pred_last = (pred_set == LAST_SET);
        done_mask = LLC_WAYS'(1) << wb_way;
        case (state_reg)
            FL_SCAN: enc_in = valid_buf & dirty_buf;
            FL_WB:   enc_in = handshake ? (pend_reg & ~done_mask) : pend_reg;
            default: enc_in = pend_reg;
        endcase
        enc_tag = (state_reg == FL_SCAN) ? tags_buf[enc_way] : tag_reg[enc_way];
    end

    llc_way_prio_enc #(
        .WAYS (LLC_WAYS)
    ) u_prio_enc (
        .mask (enc_in),
        .way  (enc_way),
        .any  (enc_any)
    );

    // Tags are captured once per set, in the cycle the read data is valid.
    always_ff @(posedge clk) begin
        if (state_reg == FL_SCAN) begin
            tag_reg <= tags_buf;
        end
    end

    // Walk FSM; every output is the registered value for the state entered.
    always_ff @(posedge clk) begin
        if (!rst || rst_state) begin
            state_reg                  <= IDLE;
            pend_reg                   <= '0;
            rd_set_en                  <= 1'b0;
            wr_inv_set_en              <= 1'b0;
            wb_valid                   <= 1'b0;
            wb_way                     <= '0;
            wb_line_addr               <= '0;
            incr_rst_flush_stalled_set <= 1'b0;
            clr_rst_flush_stalled_set  <= 1'b0;
            clr_rst_stall              <= 1'b0;
            clr_flush_stall            <= 1'b0;
            busy                       <= 1'b0;
        end else begin
            rd_set_en                  <= 1'b0;
            wr_inv_set_en              <= 1'b0;
            wb_valid                   <= 1'b0;
            wb_way                     <= '0;
            wb_line_addr               <= '0;
            incr_rst_flush_stalled_set <= 1'b0;
            clr_rst_flush_stalled_set  <= 1'b0;
            clr_rst_stall              <= 1'b0;
            clr_flush_stall            <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (rst_stall) begin
                        state_reg                  <= RST_CLR;
                        busy                       <= 1'b1;
                        wr_inv_set_en              <= 1'b1;
                        incr_rst_flush_stalled_set <= ~pred_last;
                        clr_rst_flush_stalled_set  <= pred_last;
                        clr_rst_stall              <= pred_last;
                    end else if (flush_stall) begin
                        state_reg <= FL_RD;
                        busy      <= 1'b1;
                        rd_set_en <= 1'b1;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                RST_CLR: begin
                    if (clr_rst_stall) begin
                        state_reg <= IDLE;
                        busy      <= 1'b0;
                    end else begin
                        wr_inv_set_en              <= 1'b1;
                        incr_rst_flush_stalled_set <= ~pred_last;
                        clr_rst_flush_stalled_set  <= pred_last;
                        clr_rst_stall              <= pred_last;
                    end
                end
                FL_RD: begin
                    state_reg <= FL_SCAN;
                end
                FL_SCAN, FL_WB: begin
                    pend_reg <= enc_in;
                    if (enc_any) begin
                        state_reg    <= FL_WB;
                        wb_valid     <= 1'b1;
                        wb_way       <= enc_way;
                        wb_line_addr <= {enc_tag, rst_flush_stalled_set};
                    end else begin
                        state_reg                  <= FL_INV;
                        wr_inv_set_en              <= 1'b1;
                        incr_rst_flush_stalled_set <= ~pred_last;
                        clr_rst_flush_stalled_set  <= pred_last;
                        clr_flush_stall            <= pred_last;
                    end
                end
                FL_INV: begin
                    if (clr_flush_stall) begin
                        state_reg <= IDLE;
                        busy      <= 1'b0;
                    end else begin
                        state_reg <= FL_RD;
                        rd_set_en <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

`ifdef LLC_FLUSH_WB_CNT_EN
    // Count accepted writebacks of the most recent flush, saturating.
    always_ff @(posedge clk) begin
        if (!rst || rst_state) begin
            flush_wb_cnt <= '0;
        end else if (state_reg == IDLE && !rst_stall && flush_stall) begin
            flush_wb_cnt <= '0;
        end else if (handshake && flush_wb_cnt != WB_CNT_MAX) begin
            flush_wb_cnt <= flush_wb_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_llc_rst_flush_seq.sv
// Bench for llc_rst_flush_seq: 4 sets x 4 ways, with register-file and
// tag/state RAM models. Expected writebacks and invalidated sets are queued
// when a walk is requested and popped by an independent monitor.
`timescale 1ns/1ps
module tb_llc_rst_flush_seq;

    localparam int SETS  = 4;
    localparam int WAYS  = 4;
    localparam int TAGB  = 8;
    localparam int SETB  = 2;
    localparam int WAYB  = 2;
    localparam int LINEB = TAGB + SETB;
    localparam logic [SETB-1:0] LAST = SETB'(SETS - 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst, rst_state;
    logic             rst_stall, flush_stall;
    logic [SETB-1:0]  cur_set;
    logic [TAGB-1:0]  tags_buf [WAYS];
    logic [WAYS-1:0]  valid_buf, dirty_buf;
    logic             rd_set_en, wr_inv_set_en, wb_valid, wb_ready;
    logic [LINEB-1:0] wb_line_addr;
    logic [WAYB-1:0]  wb_way;
    logic             incr_set, clr_set, clr_rst_stall, clr_flush_stall, busy;
`ifdef LLC_FLUSH_WB_CNT_EN
    logic [15:0]      flush_wb_cnt;
`endif

    llc_rst_flush_seq #(
        .LLC_WAYS (WAYS),
        .LLC_SETS (SETS),
        .TAG_BITS (TAGB)
    ) dut (
        .clk                        (clk),
        .rst                        (rst),
        .rst_state                  (rst_state),
        .rst_stall                  (rst_stall),
        .flush_stall                (flush_stall),
        .rst_flush_stalled_set      (cur_set),
        .tags_buf                   (tags_buf),
        .valid_buf                  (valid_buf),
        .dirty_buf                  (dirty_buf),
        .rd_set_en                  (rd_set_en),
        .wr_inv_set_en              (wr_inv_set_en),
        .wb_valid                   (wb_valid),
        .wb_ready                   (wb_ready),
        .wb_line_addr               (wb_line_addr),
        .wb_way                     (wb_way),
        .incr_rst_flush_stalled_set (incr_set),
        .clr_rst_flush_stalled_set  (clr_set),
        .clr_rst_stall              (clr_rst_stall),
        .clr_flush_stall            (clr_flush_stall),
        .busy                       (busy)
`ifdef LLC_FLUSH_WB_CNT_EN
        ,
        .flush_wb_cnt               (flush_wb_cnt)
`endif
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Register-file model: stall flags and current walk set.
    logic req_rst   = 1'b0;
    logic req_flush = 1'b0;
    always @(posedge clk) begin
        if (!rst || rst_state) begin
            rst_stall   <= 1'b0;
            flush_stall <= 1'b0;
            cur_set     <= '0;
        end else begin
            if (clr_rst_stall)        rst_stall <= 1'b0;
            else if (req_rst)         rst_stall <= 1'b1;
            if (clr_flush_stall)      flush_stall <= 1'b0;
            else if (req_flush)       flush_stall <= 1'b1;
            if (clr_set)              cur_set <= '0;
            else if (incr_set)        cur_set <= cur_set + 1'b1;
        end
    end

    // Tag/state RAM model: read data appears the cycle after rd_set_en.
    logic [TAGB-1:0] mem_tag   [SETS][WAYS];
    logic [WAYS-1:0] mem_valid [SETS];
    logic [WAYS-1:0] mem_dirty [SETS];
    always @(posedge clk) begin
        if (rd_set_en) begin
            for (int w = 0; w < WAYS; w++) tags_buf[w] <= mem_tag[cur_set][w];
            valid_buf <= mem_valid[cur_set];
            dirty_buf <= mem_dirty[cur_set];
        end
    end

    // wb_ready driver: 0 random, 1 always, 2 stall first N valid cycles, 3 never.
    int ready_mode = 1;
    int stall_left = 0;
    initial begin
        wb_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: wb_ready = 1'($urandom_range(0, 1));
                1: wb_ready = 1'b1;
                2: begin
                    if (wb_valid && stall_left > 0) begin
                        wb_ready = 1'b0;
                        stall_left--;
                    end else begin
                        wb_ready = 1'b1;
                    end
                end
                default: wb_ready = 1'b0;
            endcase
        end
    end

    // Scoreboard queues.
    logic [LINEB+WAYB-1:0] exp_wb [$];
    logic [SETB-1:0]       exp_inv [$];

    int   cyc = 0;
    int   busy_cnt = 0, stall_cnt = 0;
    int   n_clr_rst = 0, n_clr_fl = 0;
    int   clr_rst_cyc = 0, first_rd_cyc = -1;
    logic prev_stall = 1'b0;
    logic [LINEB+WAYB-1:0] prev_wb = '0;

    // Monitor: compares DUT activity against queued expectations.
    always @(negedge clk) begin
        cyc++;
        if (!rst || rst_state) begin
            prev_stall = 1'b0;
        end else begin
            if (busy) busy_cnt++;
            if (prev_stall)
                check("wb_hold", {wb_valid, wb_line_addr, wb_way}, {1'b1, prev_wb});
            if (wb_valid && wb_ready) begin
                if (exp_wb.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL wb_unexpected: got line %0h way %0d expected no writeback", wb_line_addr, wb_way);
                end else begin
                    check("wb_line", {wb_line_addr, wb_way}, exp_wb.pop_front());
                end
            end
            if (wb_valid && !wb_ready) stall_cnt++;
            prev_stall = wb_valid && !wb_ready;
            prev_wb    = {wb_line_addr, wb_way};
            if (wr_inv_set_en) begin
                if (exp_inv.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL inv_unexpected: got invalidate of set %0d expected none", cur_set);
                end else begin
                    check("inv_set", cur_set, exp_inv.pop_front());
                end
                check("inv_pulses", {incr_set, clr_set}, (cur_set == LAST) ? 2'b01 : 2'b10);
            end else if (incr_set || clr_set) begin
                n_cmp++; n_fail++;
                $display("FAIL set_pulse: got incr=%0d clr=%0d expected none without invalidate", incr_set, clr_set);
            end
            if (clr_rst_stall) begin
                n_clr_rst++;
                clr_rst_cyc = cyc;
            end
            if (clr_flush_stall) n_clr_fl++;
            if (rd_set_en && first_rd_cyc < 0) first_rd_cyc = cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string name, input int budget);
        int k = 0;
        while ((busy || rst_stall || flush_stall) && k < budget) begin
            tick();
            k++;
        end
        if (k >= budget) begin
            n_cmp++; n_fail++;
            $display("FAIL %s_timeout: got still busy after %0d cycles expected idle", name, budget);
        end
        tick();
    endtask

    // mode 0: clean; 1: random valid/dirty; 2: everything valid and dirty.
    task automatic fill_mem(input int mode);
        for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) mem_tag[s][w] = TAGB'($urandom);
            mem_valid[s] = (mode == 2) ? '1 : WAYS'($urandom);
            mem_dirty[s] = (mode == 0) ? '0 : (mode == 2) ? '1 : WAYS'($urandom);
        end
    endtask

    task automatic push_rst_walk();
        for (int s = 0; s < SETS; s++) exp_inv.push_back(SETB'(s));
    endtask

    // Reference: each set in order, every valid+dirty way lowest first.
    task automatic push_flush(output int nwb);
        nwb = 0;
        for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) begin
                if (mem_valid[s][w] && mem_dirty[s][w]) begin
                    exp_wb.push_back({mem_tag[s][w], SETB'(s), WAYB'(w)});
                    nwb++;
                end
            end
            exp_inv.push_back(SETB'(s));
        end
    endtask

    task automatic launch(input logic do_rst, input logic do_fl);
        busy_cnt  = 0;
        stall_cnt = 0;
        req_rst   = do_rst;
        req_flush = do_fl;
        tick();
        req_rst   = 1'b0;
        req_flush = 1'b0;
    endtask

    function automatic logic [19:0] all_outs();
        return {rd_set_en, wr_inv_set_en, wb_valid, wb_way, wb_line_addr,
                incr_set, clr_set, clr_rst_stall, clr_flush_stall, busy};
    endfunction

    initial begin
        int nwb;
        int clr_before;
        int k;
        rst       = 1'b0;
        rst_state = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        @(negedge clk);
        check("reset_outs", all_outs(), '0);
`ifdef LLC_FLUSH_WB_CNT_EN
        check("reset_cnt", flush_wb_cnt, 0);
`endif
        tick();

        // Reset walk.
        push_rst_walk();
        launch(1'b1, 1'b0);
        wait_done("rst_walk", 50);
        check("rst_walk_busy", busy_cnt, SETS);
        check("rst_walk_clr", n_clr_rst, 1);
        check("rst_walk_left", exp_inv.size(), 0);
        $display("txn rst_walk busy=%0d", busy_cnt);

        // Clean flush.
        fill_mem(0);
        ready_mode = 0;
        push_flush(nwb);
        launch(1'b0, 1'b1);
        wait_done("clean_flush", 100);
        check("clean_busy", busy_cnt, 3 * SETS + nwb);
        check("clean_clr", n_clr_fl, 1);
        check("clean_left", exp_inv.size() + exp_wb.size(), 0);
        $display("txn clean_flush busy=%0d", busy_cnt);

        // Directed set 2 pattern, ready held high.
        fill_mem(0);
        mem_valid[2] = 4'b1011;
        mem_dirty[2] = 4'b1010;
        ready_mode = 1;
        push_flush(nwb);
        launch(1'b0, 1'b1);
        wait_done("set2_flush", 100);
        check("set2_busy", busy_cnt, 3 * SETS + nwb);
        check("set2_left", exp_inv.size() + exp_wb.size(), 0);
        check("set2_clr", n_clr_fl, 2);
`ifdef LLC_FLUSH_WB_CNT_EN
        check("set2_cnt", flush_wb_cnt, nwb);
`endif
        $display("txn set2_flush wb=%0d busy=%0d", nwb, busy_cnt);

        // Same contents, wb_ready low for the first 5 valid cycles.
        ready_mode = 2;
        stall_left = 5;
        push_flush(nwb);
        launch(1'b0, 1'b1);
        wait_done("stall_flush", 100);
        check("stall_busy", busy_cnt, 3 * SETS + nwb + 5);
        check("stall_cycles", stall_cnt, 5);
        check("stall_left", exp_inv.size() + exp_wb.size(), 0);
        $display("txn stall_flush wb=%0d busy=%0d", nwb, busy_cnt);

        // Random flushes with random backpressure.
        ready_mode = 0;
        for (int r = 0; r < 6; r++) begin
            fill_mem(1);
            push_flush(nwb);
            launch(1'b0, 1'b1);
            wait_done("rand_flush", 300);
            check("rand_busy", busy_cnt, 3 * SETS + nwb + stall_cnt);
            check("rand_left", exp_inv.size() + exp_wb.size(), 0);
`ifdef LLC_FLUSH_WB_CNT_EN
            check("rand_cnt", flush_wb_cnt, nwb);
`endif
            $display("txn rand_flush %0d wb=%0d stalls=%0d busy=%0d", r, nwb, stall_cnt, busy_cnt);
        end

        // Hard reset while a writeback is waiting.
        fill_mem(2);
        ready_mode = 3;
        push_flush(nwb);
        clr_before = n_clr_fl;
        launch(1'b0, 1'b1);
        k = 0;
        while (!wb_valid && k < 30) begin
            tick();
            k++;
        end
        if (!wb_valid) begin
            n_cmp++; n_fail++;
            $display("FAIL abort_wait: got wb_valid=0 expected 1 within 30 cycles");
        end
        rst = 1'b0;
        exp_wb.delete();
        exp_inv.delete();
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("abort_outs", all_outs(), '0);
`ifdef LLC_FLUSH_WB_CNT_EN
        check("abort_cnt", flush_wb_cnt, 0);
`endif
        repeat (10) tick();
        check("abort_no_clr", n_clr_fl, clr_before);
        check("abort_idle", busy, 0);
        $display("txn abort_flush");
        ready_mode = 0;

        // Soft reset in the middle of a reset walk.
        push_rst_walk();
        clr_before = n_clr_rst;
        launch(1'b1, 1'b0);
        tick();
        tick();
        rst_state = 1'b1;
        exp_inv.delete();
        tick();
        rst_state = 1'b0;
        @(negedge clk);
        check("soft_outs", all_outs(), '0);
        repeat (6) tick();
        check("soft_no_clr", n_clr_rst, clr_before);
        $display("txn soft_abort");

        // Reset and flush requested together: reset walk first.
        fill_mem(1);
        push_rst_walk();
        push_flush(nwb);
        first_rd_cyc = -1;
        clr_before = n_clr_fl;
        launch(1'b1, 1'b1);
        wait_done("both", 300);
        check("both_order", first_rd_cyc - clr_rst_cyc, 2);
        check("both_left", exp_inv.size() + exp_wb.size(), 0);
        check("both_clr_fl", n_clr_fl, clr_before + 1);
        $display("txn both wb=%0d", nwb);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
